input_debouncer: RTL and testbench

- Conditions a raw, asynchronous, bouncy input (pushbutton, external strobe) into a clean, clock-synchronous level.
- Sits directly upstream of the edgedetector stage: clean_o drives edgedetector.a_i.
- Guarantees that edgedetector sees at most one rising/falling pulse per real transition.
- Also reports rejected bounces (glitches) for diagnostics.

---
 rtl/input_debouncer.sv | 177 +++++++++++++++++
 tb/tb_input_debouncer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes a raw asynchronous input and only lets a new
// level through to clean_o after it has been seen for DEBOUNCE_CYCLES
// consecutive synchronized cycles. Aborted transitions are reported as
// glitches: a one-cycle pulse plus a saturating counter.
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RESET_LEVEL     = 0,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                raw_i,
    input  logic                glitch_clr_i,
    output logic                clean_o,
    output logic                stable_o,
    output logic                glitch_o,
    output logic [GLITCH_W-1:0] glitch_cnt_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic RST_LVL = (RESET_LEVEL != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    // Last count value before the new level is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GCNT_ZERO = {GLITCH_W{1'b0}};
    localparam logic [GLITCH_W-1:0] GCNT_MAX = {GLITCH_W{1'b1}};

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } state_t;

    localparam state_t RESET_STATE = RST_LVL ? STABLE_HIGH : STABLE_LOW;

    // Saturating increment for the glitch counter.
    function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
        logic [GLITCH_W-1:0] r;
        if (v == GCNT_MAX) begin
            r = v;
        end else begin
            r = v + {{(GLITCH_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   stable_q, stable_d;
    logic                   glitch_q, glitch_d;
    logic [GLITCH_W-1:0]    gcnt_q, gcnt_d;
    logic                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Synchronizer chain: shift raw_i in at stage 0.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    end

    // Debounce FSM: next state, run counter, clean level and glitch event.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clean_d  = clean_q;
        glitch_d = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (sync_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_HIGH;
                        clean_d = 1'b1;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = CHECK_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            CHECK_HIGH: begin
                if (sync_s) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_HIGH;
                        clean_d = 1'b1;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d  = STABLE_LOW;
                    cnt_d    = CNT_ZERO;
                    glitch_d = 1'b1;
                end
            end
            STABLE_HIGH: begin
                if (!sync_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_LOW;
                        clean_d = 1'b0;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = CHECK_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            CHECK_LOW: begin
                if (!sync_s) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_LOW;
                        clean_d = 1'b0;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d  = STABLE_HIGH;
                    cnt_d    = CNT_ZERO;
                    glitch_d = 1'b1;
                end
            end
            default: begin
                state_d = RESET_STATE;
                cnt_d   = CNT_ZERO;
                clean_d = RST_LVL;
            end
        endcase
        stable_d = (state_d == STABLE_LOW) || (state_d == STABLE_HIGH);
    end

    // Glitch counter: clear wins over a coincident increment.
    always_comb begin
        if (glitch_clr_i) begin
            gcnt_d = GCNT_ZERO;
        end else if (glitch_d) begin
            gcnt_d = sat_inc(gcnt_q);
        end else begin
            gcnt_d = gcnt_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= {SYNC_STAGES{RST_LVL}};
            state_q  <= RESET_STATE;
            cnt_q    <= CNT_ZERO;
            clean_q  <= RST_LVL;
            stable_q <= 1'b1;
            glitch_q <= 1'b0;
            gcnt_q   <= GCNT_ZERO;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clean_q  <= clean_d;
            stable_q <= stable_d;
            glitch_q <= glitch_d;
            gcnt_q   <= gcnt_d;
        end
    end

    assign clean_o      = clean_q;
    assign stable_o     = stable_q;
    assign glitch_o     = glitch_q;
    assign glitch_cnt_o = gcnt_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Testbench for input_debouncer: directed vector table, hand-written corner
// sequences and random stimulus checked against a run-length reference model.
module tb_input_debouncer;

    localparam int S  = 2;
    localparam int D  = 4;
    localparam int GW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          raw_i = 1'b0;
    logic          glitch_clr_i = 1'b0;
    logic          clean_o, stable_o, glitch_o;
    logic [GW-1:0] glitch_cnt_o;
    logic          clean1, stable1, glitch1;
    logic [GW-1:0] gcnt1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    input_debouncer #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .RESET_LEVEL(0), .GLITCH_W(GW)) dut (
        .clk(clk), .rst(rst), .raw_i(raw_i), .glitch_clr_i(glitch_clr_i),
        .clean_o(clean_o), .stable_o(stable_o), .glitch_o(glitch_o), .glitch_cnt_o(glitch_cnt_o)
    );

    input_debouncer #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(0), .GLITCH_W(GW)) dut1 (
        .clk(clk), .rst(rst), .raw_i(raw_i), .glitch_clr_i(glitch_clr_i),
        .clean_o(clean1), .stable_o(stable1), .glitch_o(glitch1), .glitch_cnt_o(gcnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FSM sees the raw sample taken S edges earlier;
    // clean flips after D consecutive samples differing from it, and a run
    // broken early is a glitch.
    bit m_clean = 1'b0, m_glitch = 1'b0, m1_clean = 1'b0;
    int m_run = 0, m_gcnt = 0;
    bit mq[$];
    bit m1q[$];

    always @(posedge clk or posedge rst) begin
        bit s_used;
        bit nclean;
        bit g;
        int nrun;
        int ncnt;
        if (rst) begin
            mq.delete();
            m1q.delete();
            for (int i = 0; i < S; i++) begin
                mq.push_back(1'b0);
                m1q.push_back(1'b0);
            end
            m_clean  <= 1'b0;
            m_run    <= 0;
            m_glitch <= 1'b0;
            m_gcnt   <= 0;
            m1_clean <= 1'b0;
        end else begin
            s_used = mq.pop_front();
            mq.push_back(raw_i);
            m1_clean <= m1q.pop_front();
            m1q.push_back(raw_i);
            nclean = m_clean;
            nrun = 0;
            g = 1'b0;
            if (s_used != m_clean) begin
                nrun = m_run + 1;
                if (nrun >= D) begin
                    nclean = s_used;
                    nrun = 0;
                end
            end else if (m_run > 0) begin
                g = 1'b1;
            end
            ncnt = m_gcnt;
            if (glitch_clr_i) ncnt = 0;
            else if (g && ncnt < (1 << GW) - 1) ncnt = ncnt + 1;
            m_clean  <= nclean;
            m_run    <= nrun;
            m_glitch <= g;
            m_gcnt   <= ncnt;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            chk("m_clean", 32'(clean_o), 32'(m_clean));
            chk("m_stable", 32'(stable_o), 32'(m_run == 0));
            chk("m_glitch", 32'(glitch_o), 32'(m_glitch));
            chk("m_gcnt", 32'(glitch_cnt_o), 32'(m_gcnt));
            chk("d1_clean", 32'(clean1), 32'(m1_clean));
            chk("d1_stable", 32'(stable1), 32'd1);
            chk("d1_glitch", 32'(glitch1), 32'd0);
            chk("d1_gcnt", 32'(gcnt1), 32'd0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       raw;
        logic       clr;
        logic       clean;
        logic       stable;
        logic       glitch;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int rises;
        int gl;
        bit clean_prev;
        bit found;
        logic [11:0] pat;
        int len;

        // raw, clr, clean, stable, glitch, cnt (one entry per clock edge)
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};

        // Reset and idle low.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_clean", 32'(clean_o), 32'd0);
        chk("rst_stable", 32'(stable_o), 32'd1);
        chk("rst_glitch", 32'(glitch_o), 32'd0);
        chk("rst_gcnt", 32'(glitch_cnt_o), 32'd0);
        repeat (20) @(negedge clk);
        chk("idle_clean", 32'(clean_o), 32'd0);
        chk("idle_gcnt", 32'(glitch_cnt_o), 32'd0);

        // Vector table: clean rise, one-cycle bounce, clear.
        rises = 0;
        clean_prev = clean_o;
        for (int i = 0; i < 13; i++) begin
            raw_i = tbl[i].raw;
            glitch_clr_i = tbl[i].clr;
            @(negedge clk);
            if (clean_o && !clean_prev) rises++;
            clean_prev = clean_o;
            chk($sformatf("tbl%0d_clean", i), 32'(clean_o), 32'(tbl[i].clean));
            chk($sformatf("tbl%0d_stable", i), 32'(stable_o), 32'(tbl[i].stable));
            chk($sformatf("tbl%0d_glitch", i), 32'(glitch_o), 32'(tbl[i].glitch));
            chk($sformatf("tbl%0d_cnt", i), 32'(glitch_cnt_o), 32'(tbl[i].cnt));
        end
        glitch_clr_i = 1'b0;
        chk("edge_rises", rises, 32'd1);

        // Return low, then bounce 1,0,1,0 in 3-cycle segments and hold 1.
        raw_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("fall_clean", 32'(clean_o), 32'd0);
        pat = 12'b000111000111;
        gl = 0;
        for (int k = 0; k < 20; k++) begin
            raw_i = (k < 12) ? pat[k] : 1'b1;
            @(negedge clk);
            if (glitch_o) gl++;
            if (k == 16) chk("bounce_clean_hold", 32'(clean_o), 32'd0);
            if (k == 17) chk("bounce_clean_rise", 32'(clean_o), 32'd1);
        end
        chk("bounce_glitches", gl, 32'd2);
        chk("bounce_gcnt", 32'(glitch_cnt_o), 32'd2);

        // Saturation: 260 more one-cycle bounces from a low level.
        raw_i = 1'b0;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 260; k++) begin
            raw_i = 1'b1;
            @(negedge clk);
            raw_i = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("sat_gcnt", 32'(glitch_cnt_o), 32'd255);

        // Clear coincident with a glitch.
        raw_i = 1'b1;
        @(negedge clk);
        raw_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        glitch_clr_i = 1'b1;
        @(negedge clk);
        glitch_clr_i = 1'b0;
        chk("clr_glitch", 32'(glitch_o), 32'd1);
        chk("clr_gcnt", 32'(glitch_cnt_o), 32'd0);
        repeat (4) @(negedge clk);

        // Reset in the middle of CHECK_HIGH.
        raw_i = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            @(negedge clk);
            if (!stable_o) found = 1'b1;
        end
        chk("rstmid_in_check", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_clean", 32'(clean_o), 32'd0);
        chk("rstmid_stable", 32'(stable_o), 32'd1);
        chk("rstmid_glitch", 32'(glitch_o), 32'd0);
        chk("rstmid_gcnt", 32'(glitch_cnt_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 5) chk("rstrel_clean_hold", 32'(clean_o), 32'd0);
            if (n == 6) chk("rstrel_clean_rise", 32'(clean_o), 32'd1);
        end

        // Random segments checked by the model.
        for (int c = 0; c < 1500; c++) begin
            raw_i = 1'($urandom_range(0, 1));
            glitch_clr_i = ($urandom_range(0, 39) == 0);
            len = $urandom_range(1, 8);
            @(negedge clk);
            glitch_clr_i = 1'b0;
            repeat (len - 1) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
